// File: rtl/seg_scan_rx_if.sv
// Board-facing 7-segment bus as seen by the loopback receiver,
// plus the decoded results it hands back.
interface seg_scan_rx_if #(
   parameter int DIGITS = 6
);
   logic [DIGITS-1:0]   sel;
   logic [7:0]          seg;
   logic [4*DIGITS-1:0] digits;
   logic [DIGITS-1:0]   dp;
   logic                frame_vld;
   logic                err;

   modport master (output sel, seg, input digits, dp, frame_vld, err);
   modport slave  (input sel, seg, output digits, dp, frame_vld, err);
endinterface

// File: rtl/seg_scan_rx.sv
// Multiplexed common-anode 7-segment bus receiver: qualifies stable
// select/segment pairs and decodes them back to per-digit codes.
module seg_scan_rx #(
   parameter int DIGITS = 6,
   parameter int STABLE = 4
) (
   input logic          clk,
   input logic          rst_n,
   seg_scan_rx_if.slave bus
);
   localparam int W  = DIGITS + 8;
   localparam int CW = $clog2(STABLE + 1);

   logic [W-1:0]        s1, s2, s3;
   logic [CW-1:0]       cnt;
   logic [DIGITS-1:0]   mask, mask_n;
   logic [4*DIGITS-1:0] digits_q, digits_n;
   logic [DIGITS-1:0]   dp_q, dp_n;
   logic                frame_q, frame_n;
   logic                err_q, err_n;
   logic [DIGITS-1:0]   sel_act;
   logic                qualify;
   logic                one_hot;
   logic                bad;
   logic [3:0]          code;

   // Returns {bad, code}; blank decodes to F and is not an error.
   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'h40:   decode = 5'h00;
         7'h79:   decode = 5'h01;
         7'h24:   decode = 5'h02;
         7'h30:   decode = 5'h03;
         7'h19:   decode = 5'h04;
         7'h12:   decode = 5'h05;
         7'h02:   decode = 5'h06;
         7'h78:   decode = 5'h07;
         7'h00:   decode = 5'h08;
         7'h10:   decode = 5'h09;
         7'h7F:   decode = 5'h0F;
         default: decode = 5'h1E;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1  <= '1;
         s2  <= '1;
         s3  <= '1;
         cnt <= '0;
      end else begin
         s1 <= {bus.sel, bus.seg};
         s2 <= s1;
         s3 <= s2;
         if (s2 == s3) begin
            if (cnt != CW'(STABLE))
               cnt <= cnt + CW'(1);
         end else begin
            cnt <= '0;
         end
      end
   end

   // Firing only at STABLE-1 gives one event per stable interval, however long it is held.
   always_comb begin
      sel_act  = ~s2[W-1:8];
      qualify  = (s2 == s3) && (cnt == CW'(STABLE - 1));
      one_hot  = (sel_act != '0) && ((sel_act & (sel_act - DIGITS'(1))) == '0);
      {bad, code} = decode(s2[6:0]);
      digits_n = digits_q;
      dp_n     = dp_q;
      mask_n   = mask;
      frame_n  = 1'b0;
      err_n    = 1'b0;
      if (qualify && one_hot) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (sel_act[i]) begin
               digits_n[4*i +: 4] = code;
               dp_n[i]            = ~s2[7];
            end
         end
         err_n  = bad;
         mask_n = mask | sel_act;
         if (&mask_n) begin
            frame_n = 1'b1;
            mask_n  = '0;
         end
      end else if (qualify && (sel_act != '0)) begin
         err_n = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits_q <= '1;
         dp_q     <= '0;
         mask     <= '0;
         frame_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         digits_q <= digits_n;
         dp_q     <= dp_n;
         mask     <= mask_n;
         frame_q  <= frame_n;
         err_q    <= err_n;
      end
   end

   assign bus.digits    = digits_q;
   assign bus.dp        = dp_q;
   assign bus.frame_vld = frame_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_seg_scan_rx.sv
// Scoreboard bench for seg_scan_rx: directed bus slots queue their expected
// output events; a negedge monitor pops and compares each visible event.
module tb_seg_scan_rx;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   typedef struct {
      logic [23:0] d;
      logic [5:0]  p;
      logic        fv;
      logic        er;
      int          at;
   } ev_t;

   ev_t         exp_q[$];
   logic [23:0] prev_d = 24'hFFFFFF;
   logic [5:0]  prev_p = 6'h00;

   seg_scan_rx_if #(.DIGITS(6)) bus ();

   seg_scan_rx #(.DIGITS(6), .STABLE(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [5:0] dsel(input int i);
      logic [5:0] one;
      one = 6'b000001;
      return ~(one << i);
   endfunction

   // Drive one bus value for 'hold' cycles; a capture lands on the 7th edge.
   task automatic apply_stimulus(input logic [5:0] s, input logic [7:0] g, input int hold,
                                 input bit ev, input logic [23:0] d, input logic [5:0] p,
                                 input logic fv, input logic er);
      ev_t e;
      @(negedge clk);
      bus.sel = s;
      bus.seg = g;
      if (ev) begin
         e.d  = d;
         e.p  = p;
         e.fv = fv;
         e.er = er;
         e.at = cyc + 7;
         exp_q.push_back(e);
      end
      repeat (hold - 1) @(negedge clk);
   endtask

   task automatic gap();
      apply_stimulus(6'h3F, 8'hFF, 10, 0, 24'h0, 6'h0, 1'b0, 1'b0);
   endtask

   task automatic check_reset_values();
      check_output("reset_digits", 32'(bus.digits), 32'hFFFFFF);
      check_output("reset_dp", 32'(bus.dp), 32'h0);
      check_output("reset_frame_vld", 32'(bus.frame_vld), 32'h0);
      check_output("reset_err", 32'(bus.err), 32'h0);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.digits !== prev_d || bus.dp !== prev_p || bus.frame_vld !== 1'b0 || bus.err !== 1'b0) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("[TB] FAIL unexpected_event: got digits=%h dp=%b frame_vld=%b err=%b at cycle %0d, expected no event",
                        bus.digits, bus.dp, bus.frame_vld, bus.err, cyc);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               check_output("event_cycle", 32'(cyc), 32'(e.at));
               check_output("digits", 32'(bus.digits), 32'(e.d));
               check_output("dp", 32'(bus.dp), 32'(e.p));
               check_output("frame_vld", 32'(bus.frame_vld), 32'(e.fv));
               check_output("err", 32'(bus.err), 32'(e.er));
            end
         end
      end
      prev_d = bus.digits;
      prev_p = bus.dp;
   end

   initial begin
      bus.sel = 6'h3F;
      bus.seg = 8'hFF;
      #1 rst_n = 1'b0;
      #1 check_reset_values();
      @(negedge clk);
      #2 rst_n = 1'b1;

      // Glitch: held only 4 cycles, must never be captured.
      apply_stimulus(6'b111110, 8'hC0, 4, 0, 24'h0, 6'h0, 1'b0, 1'b0);
      gap();
      check_output("glitch_digit0", 32'(bus.digits[3:0]), 32'hF);

      // Full valid frame.
      apply_stimulus(dsel(0), 8'hF9, 10, 1, 24'hFFFFF1, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(1), 8'hA4, 10, 1, 24'hFFFF21, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(2), 8'hB0, 10, 1, 24'hFFF321, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(3), 8'h99, 10, 1, 24'hFF4321, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(4), 8'h92, 10, 1, 24'hF54321, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(5), 8'h82, 10, 1, 24'h654321, 6'h00, 1'b1, 1'b0);
      gap();

      // Bad pattern, then two digits selected at once.
      apply_stimulus(dsel(2), 8'hAA, 10, 1, 24'h654E21, 6'h00, 1'b0, 1'b1);
      apply_stimulus(6'b111100, 8'hC0, 10, 1, 24'h654E21, 6'h00, 1'b0, 1'b1);
      gap();

      // Blank digit, then zero with decimal point lit.
      apply_stimulus(dsel(0), 8'hFF, 10, 1, 24'h654E2F, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(0), 8'h40, 10, 1, 24'h654E20, 6'h01, 1'b0, 1'b0);

      // Partial frame, then reset must discard it.
      apply_stimulus(dsel(0), 8'hF9, 10, 1, 24'h654E21, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(1), 8'h99, 10, 1, 24'h654E41, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(2), 8'hB0, 10, 1, 24'h654341, 6'h00, 1'b0, 1'b0);
      gap();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_values();
      prev_d = 24'hFFFFFF;
      prev_p = 6'h00;
      #1 rst_n = 1'b1;

      apply_stimulus(dsel(3), 8'hF9, 10, 1, 24'hFF1FFF, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(4), 8'hA4, 10, 1, 24'hF21FFF, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(5), 8'hB0, 10, 1, 24'h321FFF, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(0), 8'h99, 10, 1, 24'h321FF4, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(1), 8'h92, 10, 1, 24'h321F54, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(2), 8'h82, 10, 1, 24'h321654, 6'h00, 1'b1, 1'b0);

      // Invalid pattern on the completing digit still completes the frame.
      apply_stimulus(dsel(0), 8'hC0, 10, 1, 24'h321650, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(1), 8'hC0, 10, 1, 24'h321600, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(2), 8'hC0, 10, 1, 24'h321000, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(3), 8'hC0, 10, 1, 24'h320000, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(4), 8'hC0, 10, 1, 24'h300000, 6'h00, 1'b0, 1'b0);
      apply_stimulus(dsel(5), 8'h8B, 10, 1, 24'hE00000, 6'h00, 1'b1, 1'b1);
      gap();

      repeat (3) @(negedge clk);
      check_output("pending_events", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
